// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Central stall/flush sequencer for the 5-stage MIPS pipeline. It resolves
// Tuse/Tnew data hazards against the E and M stages, tracks how long the
// HI/LO multiply/divide unit stays busy, and sequences the PC redirect plus
// bubble cycles that follow an exception or an eret. It produces control
// only; no datapath values pass through it.
//
// Parameters
//   MULT_LAT   cycles mult/multu occupies the HI/LO unit after leaving E
//   DIV_LAT    cycles div/divu occupies the HI/LO unit after leaving E
//   REDIR_BUB  bubble cycles after a redirect (F/D cleared, PC held), 0..3
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   id_rs, id_rt               source registers of the instruction in D
//   id_tuse_rs, id_tuse_rt     cycles until D needs rs/rt (3 = unused)
//   id_md                      D instruction uses the HI/LO unit
//   ex_wa, ex_tnew             dest reg / cycles-to-ready of the E instr
//   mem_wa, mem_tnew           dest reg / cycles-to-ready of the M instr
//   ex_md_start, ex_md_div     E instr starts a mult (0) or div (1)
//   exc_req, eret_req          exception / eret commit pulses from CP0
//   pc_en, fd_en, de_en        pipeline register enables
//   fd_clr, de_clr, em_clr, mw_clr  synchronous bubble-insert clears
//   pc_sel                     00 sequential, 01 exception vector, 10 EPC
//   md_busy                    HI/LO unit busy
//   stall                      hazard stall active this cycle
//
// Optional feature (macro PIPE_PERF_CNT_EN)
//   When defined, adds perf_stall (cycles with stall=1) and perf_flush
//   (number of redirect cycles), both free-running 32-bit wrapping counters
//   cleared by reset. When undefined those ports and counters do not exist.
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int unsigned MULT_LAT  = 5,
    parameter int unsigned DIV_LAT   = 10,
    parameter int unsigned REDIR_BUB = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [1:0]  id_tuse_rs,
    input  logic [1:0]  id_tuse_rt,
    input  logic        id_md,
    input  logic [4:0]  ex_wa,
    input  logic [1:0]  ex_tnew,
    input  logic [4:0]  mem_wa,
    input  logic [1:0]  mem_tnew,
    input  logic        ex_md_start,
    input  logic        ex_md_div,
    input  logic        exc_req,
    input  logic        eret_req,
    output logic        pc_en,
    output logic        fd_en,
    output logic        de_en,
    output logic        fd_clr,
    output logic        de_clr,
    output logic        em_clr,
    output logic        mw_clr,
    output logic [1:0]  pc_sel,
    output logic        md_busy,
    output logic        stall
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall,
    output logic [31:0] perf_flush
`endif
);

    localparam int unsigned MD_MAX = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int unsigned MD_W   = (MD_MAX < 2) ? 1 : $clog2(MD_MAX + 1);

    localparam logic [MD_W-1:0] MULT_LOAD = MD_W'(MULT_LAT);
    localparam logic [MD_W-1:0] DIV_LOAD  = MD_W'(DIV_LAT);
    localparam logic [1:0]      BUB_LOAD  = 2'(REDIR_BUB);

    localparam logic [1:0] SEL_SEQ  = 2'b00;
    localparam logic [1:0] SEL_EXC  = 2'b01;
    localparam logic [1:0] SEL_EPC  = 2'b10;

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_REDIR = 1'b1;

    logic [0:0]      state;
    logic [1:0]      bub_cnt;
    logic [MD_W-1:0] md_cnt;

    logic hit_rs;
    logic hit_rt;
    logic data_stall;
    logic md_stall;
    logic unit_busy;
    logic redirect;
    logic hazard;

    // A source only conflicts when it is a real register and the producer
    // cannot deliver in time through forwarding (Tuse < Tnew).
    always_comb begin
        hit_rs = ((id_rs != 5'd0) && (id_rs == ex_wa)  && (id_tuse_rs < ex_tnew)) ||
                 ((id_rs != 5'd0) && (id_rs == mem_wa) && (id_tuse_rs < mem_tnew));
        hit_rt = ((id_rt != 5'd0) && (id_rt == ex_wa)  && (id_tuse_rt < ex_tnew)) ||
                 ((id_rt != 5'd0) && (id_rt == mem_wa) && (id_tuse_rt < mem_tnew));
        data_stall = hit_rs | hit_rt;
    end

    // A HI/LO instruction in D waits while the unit is busy, including the
    // very cycle a mult/div is leaving E (the counter is not loaded yet).
    always_comb begin
        unit_busy = (md_cnt != '0);
        md_stall  = id_md && (unit_busy || ex_md_start);
    end

    // Redirect is taken in RUN on either request; in REDIR only a new
    // exception can restart it. An eret cannot be in M during REDIR because
    // the redirect cycle flushed E/M, so it is ignored there.
    always_comb begin
        redirect = !reset && (exc_req || ((state == ST_RUN) && eret_req));
        hazard   = !reset && (state == ST_RUN) && !redirect && (data_stall || md_stall);
    end

    // Output decode, highest priority first: reset, redirect cycle, bubble
    // cycles after a redirect, hazard stall, normal flow.
    always_comb begin
        pc_en   = 1'b1;
        fd_en   = 1'b1;
        de_en   = 1'b1;
        fd_clr  = 1'b0;
        de_clr  = 1'b0;
        em_clr  = 1'b0;
        mw_clr  = 1'b0;
        pc_sel  = SEL_SEQ;
        stall   = 1'b0;
        md_busy = !reset && unit_busy;
        if (reset) begin
            pc_en  = 1'b0;
            fd_en  = 1'b0;
            de_en  = 1'b0;
            fd_clr = 1'b1;
            de_clr = 1'b1;
            em_clr = 1'b1;
            mw_clr = 1'b1;
        end else if (redirect) begin
            // The excepting instruction in M must not write back; a
            // committing eret does.
            fd_clr = 1'b1;
            de_clr = 1'b1;
            em_clr = 1'b1;
            mw_clr = exc_req;
            pc_sel = exc_req ? SEL_EXC : SEL_EPC;
        end else if (state == ST_REDIR) begin
            pc_en  = 1'b0;
            fd_clr = 1'b1;
            de_clr = 1'b1;
        end else if (hazard) begin
            // Hold PC and F/D, push a bubble into E; E/M and M/W drain.
            pc_en  = 1'b0;
            fd_en  = 1'b0;
            de_clr = 1'b1;
            stall  = 1'b1;
        end
    end

    // HI/LO busy counter. A new start always reloads, even mid-operation,
    // and redirects do not touch it: an issued HI/LO op runs to completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            md_cnt <= '0;
        end else if (ex_md_start) begin
            md_cnt <= ex_md_div ? DIV_LOAD : MULT_LOAD;
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - 1'b1;
        end
    end

    // Redirect sequencer. bub_cnt holds the bubble cycles still to run,
    // including the current one, so REDIR lasts exactly REDIR_BUB cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_RUN;
            bub_cnt <= 2'd0;
        end else if (redirect) begin
            if (REDIR_BUB != 0) begin
                state   <= ST_REDIR;
                bub_cnt <= BUB_LOAD;
            end else begin
                state   <= ST_RUN;
                bub_cnt <= 2'd0;
            end
        end else if (state == ST_REDIR) begin
            if (bub_cnt <= 2'd1) begin
                state   <= ST_RUN;
                bub_cnt <= 2'd0;
            end else begin
                bub_cnt <= bub_cnt - 2'd1;
            end
        end
    end

`ifdef PIPE_PERF_CNT_EN
    // Event counters sample the same cycle the event is visible on the
    // outputs and wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall <= 32'd0;
            perf_flush <= 32'd0;
        end else begin
            if (stall) begin
                perf_stall <= perf_stall + 32'd1;
            end
            if (redirect) begin
                perf_flush <= perf_flush + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Directed bench for pipe_hazard_ctrl with default parameters
// (MULT_LAT=5, DIV_LAT=10, REDIR_BUB=1). Each stimulus cycle pushes the
// hand-computed expected control vector and a care mask into a queue; a
// monitor on the falling edge pops one entry per cycle and compares.
// Expected vector bit order:
//   [10] pc_en [9] fd_en [8] de_en [7] fd_clr [6] de_clr [5] em_clr
//   [4] mw_clr [3:2] pc_sel [1] md_busy [0] stall
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    logic        clk;
    logic        reset;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [1:0]  id_tuse_rs;
    logic [1:0]  id_tuse_rt;
    logic        id_md;
    logic [4:0]  ex_wa;
    logic [1:0]  ex_tnew;
    logic [4:0]  mem_wa;
    logic [1:0]  mem_tnew;
    logic        ex_md_start;
    logic        ex_md_div;
    logic        exc_req;
    logic        eret_req;
    logic        pc_en;
    logic        fd_en;
    logic        de_en;
    logic        fd_clr;
    logic        de_clr;
    logic        em_clr;
    logic        mw_clr;
    logic [1:0]  pc_sel;
    logic        md_busy;
    logic        stall;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] perf_stall;
    logic [31:0] perf_flush;
`endif

    int tests_run;
    int tests_failed;

    typedef struct {
        string       name;
        logic [10:0] exp;
        logic [10:0] mask;
    } sb_entry_t;

    sb_entry_t sb[$];

    // Expected vectors (md_busy bit 1 added per step where relevant).
    localparam logic [10:0] V_RESET  = 11'b000_1111_00_0_0;
    localparam logic [10:0] V_NORMAL = 11'b111_0000_00_0_0;
    localparam logic [10:0] V_STALL  = 11'b001_0100_00_0_1;
    localparam logic [10:0] V_EXC    = 11'b111_1111_01_0_0;
    localparam logic [10:0] V_ERET   = 11'b111_1110_10_0_0;
    localparam logic [10:0] V_REDIR  = 11'b011_1100_00_0_0;
    localparam logic [10:0] V_BUSY   = 11'b000_0000_00_1_0;

    localparam logic [10:0] M_ALL    = 11'h7FF;
    localparam logic [10:0] M_STALL  = 11'b101_1111_11_1_1;
    localparam logic [10:0] M_RDCT   = 11'b100_1111_11_1_1;
    localparam logic [10:0] M_REDIR  = 11'b100_1100_11_1_1;

    pipe_hazard_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_tuse_rs  (id_tuse_rs),
        .id_tuse_rt  (id_tuse_rt),
        .id_md       (id_md),
        .ex_wa       (ex_wa),
        .ex_tnew     (ex_tnew),
        .mem_wa      (mem_wa),
        .mem_tnew    (mem_tnew),
        .ex_md_start (ex_md_start),
        .ex_md_div   (ex_md_div),
        .exc_req     (exc_req),
        .eret_req    (eret_req),
        .pc_en       (pc_en),
        .fd_en       (fd_en),
        .de_en       (de_en),
        .fd_clr      (fd_clr),
        .de_clr      (de_clr),
        .em_clr      (em_clr),
        .mw_clr      (mw_clr),
        .pc_sel      (pc_sel),
        .md_busy     (md_busy),
        .stall       (stall)
`ifdef PIPE_PERF_CNT_EN
        ,
        .perf_stall  (perf_stall),
        .perf_flush  (perf_flush)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Queue the expectation for the current cycle and advance one cycle.
    task automatic applyStimulus(input string name, input logic [10:0] exp,
                                 input logic [10:0] mask);
        sb_entry_t e;
        e.name = name;
        e.exp  = exp;
        e.mask = mask;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clearInputs();
        id_rs = 5'd0; id_rt = 5'd0; id_tuse_rs = 2'd3; id_tuse_rt = 2'd3;
        id_md = 1'b0; ex_wa = 5'd0; ex_tnew = 2'd0; mem_wa = 5'd0;
        mem_tnew = 2'd0; ex_md_start = 1'b0; ex_md_div = 1'b0;
        exc_req = 1'b0; eret_req = 1'b0;
    endtask

    // Monitor: one scoreboard entry per cycle, compared away from the edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            sb_entry_t e;
            logic [10:0] act;
            e = sb.pop_front();
            act = {pc_en, fd_en, de_en, fd_clr, de_clr, em_clr, mw_clr,
                   pc_sel, md_busy, stall};
            tests_run++;
            if ((act & e.mask) !== (e.exp & e.mask)) begin
                tests_failed++;
                $display("[TB] FAIL %s: got %b expected %b (mask %b)",
                         e.name, act, e.exp, e.mask);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        clearInputs();
        reset = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus("reset_state", V_RESET, M_ALL);
        reset = 1'b0;
        applyStimulus("idle_normal", V_NORMAL, M_ALL);

        // Load-use against E, then the producer becomes forwardable.
        ex_wa = 5'd5; ex_tnew = 2'd2; id_rs = 5'd5; id_tuse_rs = 2'd1;
        applyStimulus("load_use_stall", V_STALL, M_STALL);
        ex_tnew = 2'd1;
        applyStimulus("load_use_tnew1", V_NORMAL, M_ALL);

        // Register $0 never conflicts.
        clearInputs();
        ex_wa = 5'd0; ex_tnew = 2'd2; id_rs = 5'd0; id_tuse_rs = 2'd0;
        applyStimulus("reg0_no_stall", V_NORMAL, M_ALL);

        // rt hazard against M, then the Tuse==Tnew boundary.
        clearInputs();
        mem_wa = 5'd7; mem_tnew = 2'd1; id_rt = 5'd7; id_tuse_rt = 2'd0;
        applyStimulus("mem_rt_stall", V_STALL, M_STALL);
        id_tuse_rt = 2'd1;
        applyStimulus("mem_rt_equal", V_NORMAL, M_ALL);

        // Divide with a HI/LO consumer waiting in D: 11 stall cycles.
        clearInputs();
        ex_md_start = 1'b1; ex_md_div = 1'b1; id_md = 1'b1;
        applyStimulus("div_start_stall", V_STALL, M_STALL);
        ex_md_start = 1'b0; ex_md_div = 1'b0;
        for (int i = 0; i < 10; i++)
            applyStimulus("div_busy_stall", V_STALL | V_BUSY, M_STALL);
        applyStimulus("div_done", V_NORMAL, M_ALL);

        // Mult, then a div restarts the counter before the mult finishes.
        clearInputs();
        ex_md_start = 1'b1;
        applyStimulus("mult_start", V_NORMAL, M_ALL);
        ex_md_start = 1'b0;
        applyStimulus("mult_busy", V_NORMAL | V_BUSY, M_ALL);
        ex_md_start = 1'b1; ex_md_div = 1'b1;
        applyStimulus("mult_busy_reload", V_NORMAL | V_BUSY, M_ALL);
        ex_md_start = 1'b0; ex_md_div = 1'b0;
        for (int i = 0; i < 10; i++)
            applyStimulus("reload_busy", V_NORMAL | V_BUSY, M_ALL);
        applyStimulus("reload_done", V_NORMAL, M_ALL);

        // Exception: redirect, one bubble, back to normal.
        exc_req = 1'b1;
        applyStimulus("exc_redirect", V_EXC, M_RDCT);
        exc_req = 1'b0;
        applyStimulus("exc_bubble", V_REDIR, M_REDIR);
        applyStimulus("exc_after", V_NORMAL, M_ALL);

        // exc+eret together during a data stall: exception wins.
        ex_wa = 5'd5; ex_tnew = 2'd2; id_rs = 5'd5; id_tuse_rs = 2'd1;
        exc_req = 1'b1; eret_req = 1'b1;
        applyStimulus("collide_redirect", V_EXC, M_RDCT);
        exc_req = 1'b0; eret_req = 1'b0;
        applyStimulus("collide_bubble_nostall", V_REDIR, M_REDIR);
        applyStimulus("collide_stall_resumes", V_STALL, M_STALL);

        // eret alone: EPC, M/W not cleared.
        clearInputs();
        eret_req = 1'b1;
        applyStimulus("eret_redirect", V_ERET, M_RDCT);
        eret_req = 1'b0;
        applyStimulus("eret_bubble", V_REDIR, M_REDIR);
        applyStimulus("eret_after", V_NORMAL, M_ALL);

        // Exception arriving during the bubble restarts the redirect.
        exc_req = 1'b1;
        applyStimulus("exc_first", V_EXC, M_RDCT);
        applyStimulus("exc_in_redir", V_EXC, M_RDCT);
        exc_req = 1'b0;
        applyStimulus("exc_rebubble", V_REDIR, M_REDIR);
        applyStimulus("exc_rebubble_after", V_NORMAL, M_ALL);

        // Reset with the divide counter at 6.
        ex_md_start = 1'b1; ex_md_div = 1'b1;
        applyStimulus("div2_start", V_NORMAL, M_ALL);
        ex_md_start = 1'b0; ex_md_div = 1'b0;
        for (int i = 0; i < 4; i++)
            applyStimulus("div2_busy", V_NORMAL | V_BUSY, M_ALL);
        reset = 1'b1;
        applyStimulus("reset_mid_div", V_RESET, M_ALL);
        reset = 1'b0;
        applyStimulus("after_reset_div", V_NORMAL, M_ALL);
`ifdef PIPE_PERF_CNT_EN
        checkOutput("perf_stall_reset", perf_stall, 32'd0);
        checkOutput("perf_flush_reset", perf_flush, 32'd0);
`endif

        // Reset while in the bubble state.
        exc_req = 1'b1;
        applyStimulus("exc_before_reset", V_EXC, M_RDCT);
        exc_req = 1'b0;
        reset = 1'b1;
        applyStimulus("reset_in_redir", V_RESET, M_ALL);
        reset = 1'b0;
        applyStimulus("after_reset_redir", V_NORMAL, M_ALL);
`ifdef PIPE_PERF_CNT_EN
        checkOutput("perf_flush_reset2", perf_flush, 32'd0);
`endif

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 5 && sb.size() > 0; i++)
            @(posedge clk);
        if (sb.size() > 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries left expected 0",
                     sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
